// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit owning the HI/LO pair.
// Start edge -> 32 iteration cycles (CALC) -> one sign-fix cycle (FIX) -> DONE.
// Signed operands are reduced to magnitudes at start; signs are applied in FIX.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iStart,
    input  logic [2:0]        iOp,
    input  logic [DATA_W-1:0] iA,
    input  logic [DATA_W-1:0] iB,
    output logic              oBusy,
    output logic              oDone,
    output logic [DATA_W-1:0] oHI,
    output logic [DATA_W-1:0] oLO
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [DATA_W-1:0]   ONE  = 1;
    localparam logic [2*DATA_W-1:0] ONE2 = 1;

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic                isDiv;
    logic                negLo;      // negate LO (div) or whole product (mult)
    logic                negHi;      // negate remainder (div only)
    logic                divZero;
    logic [DATA_W-1:0]   opnd;       // multiplicand or divisor magnitude
    logic [DATA_W-1:0]   aRaw;       // dividend as presented, for divide-by-zero
    logic [2*DATA_W-1:0] work;       // mult: {acc, multiplier}; div: {rem, quotient}
    logic [2*DATA_W-1:0] workNext;
    logic [DATA_W:0]     addSum;
    logic [DATA_W:0]     trial;
    logic [DATA_W-1:0]   fixHi;
    logic [DATA_W-1:0]   fixLo;

    logic                canAccept;
    logic                startArith;
    logic                startMthi;
    logic                startMtlo;
    logic                signedOp;
    logic                aNeg;
    logic                bNeg;
    logic [DATA_W-1:0]   aMag;
    logic [DATA_W-1:0]   bMag;

    assign canAccept  = iStart && ((state == ST_IDLE) || (state == ST_DONE));
    assign startArith = canAccept && !iOp[2];
    assign startMthi  = canAccept && (iOp == OP_MTHI);
    assign startMtlo  = canAccept && (iOp == OP_MTLO);

    // MULT and DIV (op bit 0 clear) treat operands as two's complement.
    assign signedOp = !iOp[0];
    assign aNeg     = signedOp && iA[DATA_W-1];
    assign bNeg     = signedOp && iB[DATA_W-1];
    assign aMag     = aNeg ? (~iA + ONE) : iA;
    assign bMag     = bNeg ? (~iB + ONE) : iB;

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        workNext = work;
        addSum   = {1'b0, work[2*DATA_W-1:DATA_W]} + (work[0] ? {1'b0, opnd} : '0);
        trial    = {work[2*DATA_W-1:DATA_W], work[DATA_W-1]} - {1'b0, opnd};
        if (isDiv) begin
            if (trial[DATA_W])
                workNext = {work[2*DATA_W-2:0], 1'b0};
            else
                workNext = {trial[DATA_W-1:0], work[DATA_W-2:0], 1'b1};
        end else begin
            workNext = {addSum, work[DATA_W-1:1]};
        end
    end

    // Sign correction and divide-by-zero override applied on the FIX edge.
    always_comb begin
        fixHi = work[2*DATA_W-1:DATA_W];
        fixLo = work[DATA_W-1:0];
        if (!isDiv) begin
            if (negLo)
                {fixHi, fixLo} = ~work + ONE2;
        end else if (divZero) begin
            fixHi = aRaw;
            fixLo = '1;
        end else begin
            if (negLo)
                fixLo = ~work[DATA_W-1:0] + ONE;
            if (negHi)
                fixHi = ~work[2*DATA_W-1:DATA_W] + ONE;
        end
    end

    // Sequencer and iteration datapath.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            isDiv   <= 1'b0;
            negLo   <= 1'b0;
            negHi   <= 1'b0;
            divZero <= 1'b0;
            opnd    <= '0;
            aRaw    <= '0;
            work    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            oDone <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (startArith) begin
                        state   <= ST_CALC;
                        oBusy   <= 1'b1;
                        cnt     <= '0;
                        isDiv   <= iOp[1];
                        negLo   <= aNeg ^ bNeg;
                        negHi   <= iOp[1] ? aNeg : (aNeg ^ bNeg);
                        divZero <= iOp[1] && (iB == '0);
                        aRaw    <= iA;
                        if (iOp[1]) begin
                            opnd <= bMag;
                            work <= {{DATA_W{1'b0}}, aMag};
                        end else begin
                            opnd <= aMag;
                            work <= {{DATA_W{1'b0}}, bMag};
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    work <= workNext;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1))
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    state <= ST_DONE;
                    oBusy <= 1'b0;
                    oDone <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // HI/LO: arithmetic result on the FIX edge, MTHI/MTLO writes when idle/done.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            oHI <= '0;
            oLO <= '0;
        end else if (state == ST_FIX) begin
            oHI <= fixHi;
            oLO <= fixLo;
        end else if (startMthi) begin
            oHI <= iA;
        end else if (startMtlo) begin
            oLO <= iA;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed stimulus with an arithmetic reference model
// (native 64-bit * / %) and a per-cycle compare of all outputs.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        iCLK   = 1'b0;
    logic        iRSTn  = 1'b1;
    logic        iStart = 1'b0;
    logic [2:0]  iOp    = 3'b111;
    logic [31:0] iA     = '0;
    logic [31:0] iB     = '0;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oHI;
    logic [31:0] oLO;

    muldiv_unit #(.DATA_W(32)) dut (
        .iCLK   (iCLK),
        .iRSTn  (iRSTn),
        .iStart (iStart),
        .iOp    (iOp),
        .iA     (iA),
        .iB     (iB),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oHI    (oHI),
        .oLO    (oLO)
    );

    always #5 iCLK = ~iCLK;

    int nCmp = 0;
    int nBad = 0;
    int busyCnt = 0;
    int doneCnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result {HI, LO} straight from the arithmetic rules.
    function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            OP_MULT:  p = 64'(sa * sb);
            OP_MULTU: p = {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Cycle-level model: a result lands 33 edges after an accepted start.
    logic        mBusy = 1'b0;
    logic        mDone = 1'b0;
    logic [31:0] mHI   = '0;
    logic [31:0] mLO   = '0;
    logic [63:0] mRes  = '0;
    int          remain = 0;

    always @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            mBusy  = 1'b0;
            mDone  = 1'b0;
            mHI    = '0;
            mLO    = '0;
            remain = 0;
        end else if (remain > 0) begin
            remain--;
            if (remain == 0) begin
                {mHI, mLO} = mRes;
                mBusy = 1'b0;
                mDone = 1'b1;
            end
        end else begin
            mDone = 1'b0;
            if (iStart) begin
                if (!iOp[2]) begin
                    mRes   = refResult(iOp, iA, iB);
                    remain = 33;
                    mBusy  = 1'b1;
                end else if (iOp == OP_MTHI) begin
                    mHI = iA;
                end else if (iOp == OP_MTLO) begin
                    mLO = iA;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge iCLK) begin
        check("busy", 64'(oBusy), 64'(mBusy));
        check("done", 64'(oDone), 64'(mDone));
        check("hi", 64'(oHI), 64'(mHI));
        check("lo", 64'(oLO), 64'(mLO));
        if (oBusy) busyCnt++;
        if (oDone) doneCnt++;
    end

    // Present a request for exactly one edge, then scramble the operands.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge iCLK); #2;
        iStart = 1'b1; iOp = op; iA = a; iB = b;
        @(posedge iCLK); #2;
        iStart = 1'b0;
        iA = $urandom;
        iB = $urandom;
    endtask

    task automatic waitDone(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge iCLK);
            if (oDone) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] expHiLo);
        busyCnt = 0;
        issue(op, a, b);
        waitDone(name);
        check({name, "_dut"}, {oHI, oLO}, expHiLo);
        check({name, "_model"}, {mHI, mLO}, expHiLo);
        check({name, "_busy_cycles"}, 64'(busyCnt), 64'd33);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 iRSTn = 1'b0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        check("rst_outputs", {30'b0, oBusy, oDone, oHI}, 64'd0);
        check("rst_lo", 64'(oLO), 64'd0);
        @(posedge iCLK); #2 iRSTn = 1'b1;

        // First MULT: latency, busy width and a single done pulse.
        doneCnt = 0;
        runOp("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
        @(negedge iCLK);
        check("mult_done_pulses", 64'(doneCnt), 64'd1);

        runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
        runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        runOp("div_7_m2", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        runOp("divu_100_7", OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        runOp("divu_zero", OP_DIVU, 32'h1234_5678, 32'h0, 64'h1234_5678_FFFF_FFFF);
        runOp("div_zero", OP_DIV, 32'h8000_0001, 32'h0, 64'h8000_0001_FFFF_FFFF);

        // MTHI from idle: visible right after the start edge, no busy.
        issue(OP_MTHI, 32'h1122_3344, 32'h0);
        check("mthi_hi", 64'(oHI), 64'h1122_3344);
        check("mthi_busy", 64'(oBusy), 64'd0);
        issue(OP_MTHI, 32'h0, 32'h0);

        // MTLO held during a MULT is ignored; MTLO in DONE is taken.
        busyCnt = 0;
        issue(OP_MULT, 32'h10, 32'h20);
        @(posedge iCLK); #2;
        iStart = 1'b1; iOp = OP_MTLO; iA = 32'hCAFE_F00D;
        repeat (5) @(posedge iCLK);
        #2 iStart = 1'b0;
        waitDone("mult_mtlo");
        check("mult_mtlo_res", {oHI, oLO}, 64'h0000_0000_0000_0200);
        #1;
        iStart = 1'b1; iOp = OP_MTLO; iA = 32'hCAFE_F00D;
        @(posedge iCLK); #2;
        iStart = 1'b0;
        check("mtlo_done_lo", 64'(oLO), 64'hCAFE_F00D);
        check("mtlo_done_busy", 64'(oBusy), 64'd0);

        // Asynchronous reset in the middle of a DIVU.
        issue(OP_DIVU, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (9) @(posedge iCLK);
        #2 iRSTn = 1'b0;
        #1;
        check("arst_busy", 64'(oBusy), 64'd0);
        check("arst_hilo", {oHI, oLO}, 64'd0);
        doneCnt = 0;
        repeat (2) @(posedge iCLK);
        #2 iRSTn = 1'b1;
        repeat (40) @(negedge iCLK);
        check("arst_no_done", 64'(doneCnt), 64'd0);
        runOp("multu_after_rst", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        runOp("mult_mixed", OP_MULT, 32'h8000_0000, 32'h0000_0002, 64'hFFFF_FFFF_0000_0000);

        repeat (3) @(negedge iCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that owns the HI/LO register pair for the CPU core. It replaces the single-cycle `*`, `/` and `%` operators on HI/LO with a 33-cycle radix-2 datapath that closes timing on FPGA. It sits beside the ALU in the EX stage:
- the control unit issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here and stalls the pipeline on `oBusy`;
- the ALU consumes `oHI`/`oLO` for MFHI/MFLO.

## Interface
Parameters:
- DATA_W, 32, operand and HI/LO width. Only 32 is supported; the iteration counter is sized $clog2(DATA_W)+1.

Ports:
- iCLK  in  1  single clock; all state changes on the rising edge.
- iRSTn  in  1  asynchronous, active-low reset.
- iStart  in  1  request strobe; sampled on the rising edge.
- iOp  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. 110 and 111 are no-ops.
- iA  in  DATA_W  rs operand; multiplicand, dividend, or MTHI/MTLO data.
- iB  in  DATA_W  rt operand; multiplier or divisor.
- oBusy  out  1  high while an arithmetic operation is in flight.
- oDone  out  1  one-cycle pulse when HI/LO take a MULT/DIV result.
- oHI  out  DATA_W  HI register.
- oLO  out  DATA_W  LO register.

## Operation
States:
- IDLE: `oBusy`=0. A rising edge with `iStart`=1 acts on `iOp`:
  - MULT/MULTU/DIV/DIVU: latch the operand magnitudes and result-sign flags, clear the counter, go to CALC.
  - MTHI/MTLO: write `iA` into HI or LO on that edge and stay in IDLE. No `oDone`.
  - 110/111: no effect.
- CALC: one iteration per cycle, 32 cycles; the counter runs 0..31.
  - Multiply: shift-add over a 64-bit {acc, multiplier} register.
  - Divide: restoring, one quotient bit per cycle.
- FIX: one cycle.
  - Apply the sign correction.
  - Write HI/LO.
  - Go to DONE.
- DONE: `oDone`=1, `oBusy`=0.
  - A new `iStart` is accepted exactly as in IDLE.
  - Otherwise return to IDLE.

Arithmetic rules:
- MULT: signed 32x32, full 64-bit product; {HI,LO} = product.
- MULTU: unsigned 32x32; {HI,LO} = product.
- DIV (signed):
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
  - -2^31 / -1 gives LO=0x80000000, HI=0, with no trap.
- DIVU (unsigned): LO = quotient, HI = remainder.
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=`iA` as presented. The fixed 33-cycle latency still applies.
- Signed operations are computed on magnitudes and negated in FIX. Only the two's-complement form appears on the outputs.

Boundary conditions:
- `iStart` during CALC or FIX is ignored entirely, including MTHI/MTLO. The requester must hold the request until `oBusy`=0.
- `oHI`/`oLO` keep their previous values during CALC and FIX. They change only on the FIX edge.
- Reset asserted mid-operation:
  - aborts immediately and asynchronously;
  - state goes to IDLE and HI=LO=0;
  - no `oDone` pulse follows.
- `iA`/`iB` are sampled only on the start edge. Later changes have no effect on the result.

## Timing
- Reset values: `oBusy`=0, `oDone`=0, `oHI`=0, `oLO`=0; state IDLE.
- Start accepted on edge N:
  - `oBusy`=1 from after edge N through edge N+33.
  - HI/LO update on edge N+33.
  - `oDone`=1 for the single cycle between edges N+33 and N+34.
  - `oBusy`=0 in that cycle.
- Latency from start edge to result: 33 cycles.
- Back-to-back: a start on edge N+34 (in DONE) is accepted, giving a throughput of one op per 34 cycles.
- MTHI/MTLO: the write is visible on `oHI`/`oLO` one edge after the start edge (edge N). `oBusy` stays 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then MULT with `iA`=0xFFFFFFFE (-2), `iB`=0x00000003:
  - `oBusy` is high for 33 cycles;
  - `oDone` pulses once;
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU with `iA`=`iB`=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV cases:
  - -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU by zero with `iA`=0x12345678 -> after 33 cycles LO=0xFFFFFFFF, HI=0x12345678.
- MTLO 0xCAFEF00D while busy with a MULT:
  - the MTLO is ignored and LO ends as the MULT result.
  - MTLO issued in DONE afterwards -> LO=0xCAFEF00D on the next edge; `oBusy` stays 0.
- Deassert `iRSTn` at cycle 10 of a DIVU:
  - `oBusy`, `oHI`, `oLO` go to 0 without waiting for a clock edge;
  - no `oDone` pulse occurs;
  - a new MULTU started after reset release completes correctly.
